mem_wb_pipe_buf: RTL

- Parametrised MEM→WB stage boundary for the team's pipelined CPU.
- Replaces the fixed flop stage with a DEPTH-entry elastic buffer.
- Adds valid/ready handshake, synchronous flush, and the write-back result mux (memtoreg select).
- Adds retire and bubble performance counters; sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_pipe_buf.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe_buf
// Brief    : MEM->WB elastic stage buffer with valid/ready handshake, flush,
//            write-back result mux and saturating retire/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_buf #(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic               regwrite_m,
    input  logic               memtoreg_m,
    input  logic [DATA_W-1:0]  aluout_m,
    input  logic [DATA_W-1:0]  readdata_m,
    input  logic [RADDR_W-1:0] writereg_m,
    input  logic [INSTR_W-1:0] instr_m,

    output logic               out_valid,
    input  logic               out_ready,
    output logic               regwrite_w,
    output logic               memtoreg_w,
    output logic [DATA_W-1:0]  aluout_w,
    output logic [DATA_W-1:0]  readdata_w,
    output logic [RADDR_W-1:0] writereg_w,
    output logic [INSTR_W-1:0] instr_w,
    output logic [DATA_W-1:0]  result_w,

    output logic [CNT_W-1:0]   retired_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [OCC_W-1:0] c_occ_one = OCC_W'(1);
    localparam logic [OCC_W-1:0] c_depth   = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Payload storage; contents are don't-care after reset, so no reset here.
    logic               r_mem_regwrite [DEPTH];
    logic               r_mem_memtoreg [DEPTH];
    logic [DATA_W-1:0]  r_mem_aluout   [DEPTH];
    logic [DATA_W-1:0]  r_mem_readdata [DEPTH];
    logic [RADDR_W-1:0] r_mem_writereg [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr    [DEPTH];

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_retired_cnt;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_store;
    logic               w_retire;
    logic               w_bubble;
    logic [OCC_W-1:0]   w_count_nxt;

    // Handshake decisions depend on registered occupancy only.
    assign w_valid  = (r_count != '0);
    assign in_ready = (r_count < c_depth);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_valid & out_ready;
    assign w_store  = w_push & ~flush;
    assign w_retire = w_pop & r_mem_regwrite[r_rptr];
    assign w_bubble = out_ready & ~w_valid;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_occ_one;
            2'b01:   w_count_nxt = r_count - c_occ_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_regwrite[r_wptr] <= regwrite_m;
            r_mem_memtoreg[r_wptr] <= memtoreg_m;
            r_mem_aluout[r_wptr]   <= aluout_m;
            r_mem_readdata[r_wptr] <= readdata_m;
            r_mem_writereg[r_wptr] <= writereg_m;
            r_mem_instr[r_wptr]    <= instr_m;
        end
    end

    // Flush empties the buffer but leaves the performance counters running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            r_count <= w_count_nxt;
        end
    end

    // A pop on a flush edge still retires: WB has already consumed the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_cnt <= '0;
            r_bubble_cnt  <= '0;
        end else begin
            if (w_retire && (r_retired_cnt != c_cnt_max)) begin
                r_retired_cnt <= r_retired_cnt + c_cnt_one;
            end
            if (w_bubble && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
            end
        end
    end

    // Head payload is forced to zero whenever no entry is presented.
    always_comb begin
        out_valid  = w_valid;
        regwrite_w = 1'b0;
        memtoreg_w = 1'b0;
        aluout_w   = '0;
        readdata_w = '0;
        writereg_w = '0;
        instr_w    = '0;
        if (w_valid) begin
            regwrite_w = r_mem_regwrite[r_rptr];
            memtoreg_w = r_mem_memtoreg[r_rptr];
            aluout_w   = r_mem_aluout[r_rptr];
            readdata_w = r_mem_readdata[r_rptr];
            writereg_w = r_mem_writereg[r_rptr];
            instr_w    = r_mem_instr[r_rptr];
        end
    end

    assign result_w    = memtoreg_w ? readdata_w : aluout_w;
    assign retired_cnt = r_retired_cnt;
    assign bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire
